param_priority_encoder: RTL
===========================

// Module: param_priority_encoder
// PURPOSE
//  Parametrised, registered successor to the 8:3 one-hot encoder.
//  - Converts an IN_W-bit request vector into a binary index.
//  - Three selectable modes: strict one-hot, fixed priority, round-robin.
//  - One-entry output register with valid/ready handshakes on both sides.
//  - Sits between request sources (interrupt lines, bus requesters) and downstream decode/arbitration.
// PARAMETERS
//  IN_W   8  request vector width; legal range 2..256
//  MODE   0  0 = strict one-hot; 1 = fixed priority, lowest index wins; 2 = round-robin
//  OUT_W  -  localparam = $clog2(IN_W); index width; not overridable
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  enable     in   1      1 = accept new inputs; 0 = stall intake only
//  in_valid   in   1      enc_in is valid
//  in_ready   out  1      block can accept enc_in this cycle
//  enc_in     in   IN_W   request vector
//  out_valid  out  1      result registers hold an unconsumed result
//  out_ready  in   1      downstream consumes the result
//  enc_out    out  OUT_W  encoded index
//  out_none   out  1      accepted vector was all-zero
//  out_err    out  1      MODE 0 only: accepted vector had more than one bit set
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - out_valid, enc_out, out_none, out_err and rr_ptr all go to 0.
//   - Any pending result is discarded.
//   - Reset wins over every simultaneous event.
//  Handshake and latency:
//   - in_ready = enable & (~out_valid | out_ready); combinational, no dependence on in_valid.
//   - Accept = in_valid & in_ready.
//   - Latency is 1: the result is registered on the accept edge, and out_valid=1 the next cycle.
//   - Full throughput: accept and drain may happen in the same cycle (out_ready=1 with out_valid=1).
//   - If there is no accept and out_valid & out_ready, out_valid goes to 0 and data regs hold value.
//   - If out_valid & ~out_ready, all result regs hold stable.
//   - enable=0 blocks intake only. A pending result still drains normally.
//  Encode rules on accept:
//   - All modes, enc_in==0: enc_out=0, out_none=1, out_err=0, rr_ptr unchanged.
//   - MODE 0, exactly one bit k set: enc_out=k, out_none=0, out_err=0.
//   - MODE 0, two or more bits set: enc_out=0, out_err=1.
//   - MODE 1: enc_out = lowest set index; out_err=0.
//   - MODE 2: enc_out = first set index scanning from rr_ptr upward, wrapping IN_W-1 -> 0.
//  Round-robin pointer (MODE 2):
//   - On accept with a nonzero input: rr_ptr <= (winner==IN_W-1) ? 0 : winner+1.
//   - rr_ptr is OUT_W bits wide and never exceeds IN_W-1.
//   - In MODE 0 and MODE 1 rr_ptr stays 0.
//  Width rules:
//   - Non-power-of-two IN_W is legal; unused index codes are never produced.
//   - All result bits come from a single register; there are no combinational input-to-output paths.
// TESTING
//  T1 MODE0 IN_W=8, enc_in 1,2,4,...,128 back-to-back, out_ready=1
//     -> enc_out 0..7 on consecutive cycles, 1 cycle after each accept; out_err=0.
//  T2 MODE0, enc_in=8'h06 -> enc_out=0, out_err=1.
//     Then enc_in=0 -> out_none=1, out_err=0.
//  T3 MODE1 IN_W=12, enc_in=12'hA40 -> enc_out=6.
//     Then 12'h800 -> enc_out=11.
//  T4 MODE2 IN_W=8, enc_in=8'h81 held for 4 accepts -> enc_out 0,7,0,7.
//     Then enc_in=8'h10 with rr_ptr=1 -> 4, after which rr_ptr=5.
//  T5 Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0 and result regs stable.
//     Then out_ready=1 with in_valid=1 -> drain and new accept in the same cycle.
//     Also: enable=0 -> in_ready=0 while the pending result still drains.
//  T6 Reset mid-stream (MODE2, rr_ptr=5, out_valid=1): rst_n=0 for 1 cycle
//     -> out_valid=0 and rr_ptr=0; next enc_in=8'hFF -> enc_out=0.

Source files
------------

// File: rtl/param_priority_encoder.sv
// Registered priority encoder: IN_W-bit request vector -> binary index.
// MODE 0 strict one-hot, MODE 1 fixed priority (lowest wins), MODE 2 round-robin.
// One-entry output register with valid/ready on both sides, latency 1.

// Per-request lane: flags a request whose index is at or above the round-robin pointer.
module ppe_lane #(
    parameter int OUT_W = 3,
    parameter int IDX   = 0
) (
    input  logic [OUT_W-1:0] rr_ptr,
    input  logic             req,
    output logic             hi_req
);
    assign hi_req = req && (rr_ptr <= OUT_W'(IDX));
endmodule

module param_priority_encoder #(
    parameter  int IN_W  = 8,
    parameter  int MODE  = 0,
    localparam int OUT_W = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  enc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] enc_out,
    output logic             out_none,
    output logic             out_err
);

    logic [OUT_W-1:0] rr_ptr;
    logic [IN_W-1:0]  hi_req;
    logic             accept;
    logic             any_req;
    logic             multi_req;
    logic [OUT_W-1:0] rr_win;
    logic [OUT_W-1:0] nxt_idx;
    logic             nxt_err;
    logic [OUT_W-1:0] nxt_rr;

    // Lowest set index of a vector; zero when the vector is empty.
    function automatic logic [OUT_W-1:0] lowest(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int i = IN_W - 1; i >= 0; i--)
            if (v[i]) r = OUT_W'(i);
        return r;
    endfunction

    // Lane array masks off requests below the round-robin pointer.
    genvar g;
    generate
        for (g = 0; g < IN_W; g++) begin : g_lane
            ppe_lane #(.OUT_W(OUT_W), .IDX(g)) u_lane (
                .rr_ptr (rr_ptr),
                .req    (enc_in[g]),
                .hi_req (hi_req[g])
            );
        end
    endgenerate

    assign in_ready  = enable && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign any_req   = |enc_in;
    // v & (v-1) clears the lowest set bit; anything left means 2+ bits set.
    assign multi_req = |(enc_in & (enc_in - IN_W'(1)));
    // Wrap-around scan: first request at/above pointer, else lowest overall.
    assign rr_win    = (|hi_req) ? lowest(hi_req) : lowest(enc_in);
    assign nxt_rr    = (rr_win == OUT_W'(IN_W - 1)) ? '0 : rr_win + OUT_W'(1);

    // Mode-specific index/error selection for the vector being accepted.
    always_comb begin
        nxt_idx = '0;
        nxt_err = 1'b0;
        case (MODE)
            0: begin
                if (multi_req) nxt_err = 1'b1;
                else           nxt_idx = lowest(enc_in);
            end
            1:       nxt_idx = lowest(enc_in);
            default: nxt_idx = rr_win;
        endcase
    end

    // Result register, handshake state and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            enc_out   <= '0;
            out_none  <= 1'b0;
            out_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                enc_out   <= nxt_idx;
                out_none  <= !any_req;
                out_err   <= nxt_err;
                if (MODE == 2 && any_req) rr_ptr <= nxt_rr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
